// File: rtl/flash_loader.sv
`default_nettype none
// ============================================================================
//  Module      : flash_loader
//  Description : Initiator side of the core's memory-flash port. Assembles a
//                little-endian byte stream (valid/ready) into WIDTH-bit words
//                and writes them to consecutive byte addresses starting at
//                BASE_ADDR, one flash_en pulse per word. Holds the core in
//                reset until the requested number of words has been written.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start, num_words   - launch a load of num_words words
//                in_data/in_valid/in_ready - byte stream, valid/ready handshake
//                flash_addr/flash_data/flash_en - word write port to the core
//                core_rst           - core reset, high until the load is DONE
//                busy, done         - load in progress / load complete (level)
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_loader #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             core_rst,
    output logic             busy,
    output logic             done
);

    localparam int               c_BYTES     = WIDTH / 8;
    localparam int               c_BC_W      = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_BC_W-1:0] c_LAST_BYTE = c_BC_W'(c_BYTES - 1);
    localparam logic [WIDTH-1:0] c_ADDR_STEP = WIDTH'(c_BYTES);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_WRITE   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [c_BC_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [CNT_W-1:0]  r_num_words;
    logic [WIDTH-1:0]  r_word;
    logic [WIDTH-1:0]  w_word_next;
    logic              w_accept;
    logic              w_last_byte;
    logic              w_last_word;

    // in_ready is itself a register that is only high in COLLECT, so the
    // handshake can be taken straight from it.
    assign w_accept    = (r_state == c_COLLECT) && in_valid && in_ready;
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    // num_words is never zero while in WRITE, so the subtraction cannot wrap.
    assign w_last_word = (r_word_cnt == (r_num_words - c_CNT_ONE));

    // Word with the current byte merged in; lets flash_data be loaded on the
    // same edge that accepts the final byte.
    always_comb begin
        w_word_next                      = r_word;
        w_word_next[8*r_byte_cnt +: 8]   = in_data;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_next_state = (num_words == '0) ? c_DONE : c_COLLECT;
                end
            end
            c_COLLECT: begin
                if (w_accept && w_last_byte) begin
                    w_next_state = c_WRITE;
                end
            end
            c_WRITE: begin
                w_next_state = w_last_word ? c_DONE : c_COLLECT;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready    <= 1'b0;
            flash_addr  <= BASE_ADDR;
            flash_data  <= '0;
            flash_en    <= 1'b0;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            r_byte_cnt  <= '0;
            r_word_cnt  <= '0;
            r_num_words <= '0;
            r_word      <= '0;
        end else begin
            in_ready <= (w_next_state == c_COLLECT);
            flash_en <= (w_next_state == c_WRITE);
            busy     <= (w_next_state == c_COLLECT) || (w_next_state == c_WRITE);
            done     <= (w_next_state == c_DONE);
            core_rst <= (w_next_state != c_DONE);

            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_num_words <= num_words;
                        flash_addr  <= BASE_ADDR;
                        r_word_cnt  <= '0;
                        r_byte_cnt  <= '0;
                    end
                end
                c_COLLECT: begin
                    if (w_accept) begin
                        r_word <= w_word_next;
                        if (w_last_byte) begin
                            r_byte_cnt <= '0;
                            flash_data <= w_word_next;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                c_WRITE: begin
                    flash_addr <= flash_addr + c_ADDR_STEP;
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_flash_loader
//  Description : Directed self-checking bench for flash_loader. A second
//                instance with BASE_ADDR near the top of the address space
//                exercises address wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start2;
    logic [15:0] num_words;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        in_ready,   in_ready2;
    logic [31:0] flash_addr, flash_addr2;
    logic [31:0] flash_data, flash_data2;
    logic        flash_en,   flash_en2;
    logic        core_rst,   core_rst2;
    logic        busy,       busy2;
    logic        done,       done2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sel      = 0;
    int low_rdy  = 0;
    logic prev_en = 1'b0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];
    logic [31:0] q2_addr[$];
    logic [31:0] q2_data[$];

    flash_loader #(.WIDTH(32), .BASE_ADDR(32'h0000_0000), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flash_addr(flash_addr), .flash_data(flash_data), .flash_en(flash_en),
        .core_rst(core_rst), .busy(busy), .done(done)
    );

    flash_loader #(.WIDTH(32), .BASE_ADDR(32'hFFFF_FFFC), .CNT_W(16)) u_wrap (
        .clk(clk), .rst(rst), .start(start2), .num_words(num_words),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .flash_addr(flash_addr2), .flash_data(flash_data2), .flash_en(flash_en2),
        .core_rst(core_rst2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (flash_en) begin
            check("en_with_ready_low", in_ready, 1'b0);
            check("no_back_to_back", prev_en, 1'b0);
            q_addr.push_back(flash_addr);
            q_data.push_back(flash_data);
            q_cyc.push_back(cyc);
        end
        if (busy && !in_ready) low_rdy++;
        prev_en = flash_en;
        if (flash_en2) begin
            q2_addr.push_back(flash_addr2);
            q2_data.push_back(flash_data2);
        end
    end

    // Returns on the falling edge after the start edge.
    task automatic start_load(input logic [15:0] n, input int which);
        @(negedge clk);
        num_words = n;
        in_valid  = 1'b0;
        if (which != 0) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Returns just after the posedge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!((sel != 0) ? in_ready2 : in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_bound", (n < 50), 1'b1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(tmp[8*i +: 8], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!((sel != 0) ? done2 : done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_wait_bound", (n < 200), 1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; num_words = 16'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_addr", flash_addr, 32'h0);
        check("rst_data", flash_data, 32'h0);
        check("rst_en", flash_en, 1'b0);
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wrap_addr", flash_addr2, 32'hFFFF_FFFC);
        rst = 1'b0;

        // 1) single word
        start_load(16'd1, 0);
        check("t1_busy", busy, 1'b1);
        send_word(32'h0010_0613, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_en", flash_en, 1'b1);
        check("t1_addr", flash_addr, 32'h0);
        check("t1_data", flash_data, 32'h0010_0613);
        check("t1_core_rst_in_write", core_rst, 1'b1);
        @(negedge clk);
        check("t1_done", done, 1'b1);
        check("t1_core_rst", core_rst, 1'b0);
        check("t1_en_off", flash_en, 1'b0);
        check("t1_busy_off", busy, 1'b0);
        check("t1_pulses", q_addr.size(), 1);

        // 2) three words, valid held high
        q_addr.delete(); q_data.delete(); q_cyc.delete(); low_rdy = 0;
        start_load(16'd3, 0);
        send_word(32'h4433_2211, 0);
        send_word(32'h8877_6655, 0);
        send_word(32'hCCBB_AA99, 0);
        drop_valid();
        wait_done();
        check("t2_pulses", q_addr.size(), 3);
        if (q_addr.size() == 3) begin
            check("t2_addr0", q_addr[0], 32'h0);
            check("t2_addr1", q_addr[1], 32'h4);
            check("t2_addr2", q_addr[2], 32'h8);
            check("t2_data0", q_data[0], 32'h4433_2211);
            check("t2_data1", q_data[1], 32'h8877_6655);
            check("t2_data2", q_data[2], 32'hCCBB_AA99);
            check("t2_period01", q_cyc[1] - q_cyc[0], 5);
            check("t2_period12", q_cyc[2] - q_cyc[1], 5);
        end
        check("t2_ready_low_cycles", low_rdy, 3);

        // 3) gapped valid, partial word not written
        q_addr.delete(); q_data.delete(); q_cyc.delete();
        start_load(16'd2, 0);
        send_word(32'hDEAD_BEEF, 3);
        send_byte(8'hBE, $urandom_range(0, 3));
        send_byte(8'hBA, $urandom_range(0, 3));
        send_byte(8'hFE, $urandom_range(0, 3));
        drop_valid();
        repeat (6) @(negedge clk);
        check("t3_partial_not_written", q_addr.size(), 1);
        check("t3_still_busy", busy, 1'b1);
        send_byte(8'hCA, 2);
        drop_valid();
        wait_done();
        check("t3_pulses", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            check("t3_addr0", q_addr[0], 32'h0);
            check("t3_addr1", q_addr[1], 32'h4);
            check("t3_data0", q_data[0], 32'hDEAD_BEEF);
            check("t3_data1", q_data[1], 32'hCAFE_BABE);
        end

        // 4) zero-word load, start during COLLECT ignored
        q_addr.delete(); q_data.delete(); q_cyc.delete();
        start_load(16'd0, 0);
        check("t4_zero_done", done, 1'b1);
        check("t4_zero_core_rst", core_rst, 1'b0);
        check("t4_zero_busy", busy, 1'b0);
        start_load(16'd1, 0);
        check("t4_core_rst_reasserted", core_rst, 1'b1);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        start     = 1'b1;
        num_words = 16'd5;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        drop_valid();
        wait_done();
        check("t4_pulses", q_addr.size(), 1);
        if (q_addr.size() == 1) check("t4_data", q_data[0], 32'h0403_0201);
        check("t4_done", done, 1'b1);

        // 5) reset mid-load
        q_addr.delete(); q_data.delete(); q_cyc.delete();
        start_load(16'd3, 0);
        send_word(32'hA5A5_0F0F, 0);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_addr_before_rst", flash_addr, 32'h4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_addr", flash_addr, 32'h0);
        check("t5_rst_data", flash_data, 32'h0);
        check("t5_rst_core_rst", core_rst, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_ready", in_ready, 1'b0);
        check("t5_rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        check("t5_no_partial_write", q_addr.size(), 1);
        start_load(16'd1, 0);
        send_word(32'h1234_5678, 0);
        drop_valid();
        wait_done();
        check("t5_pulses", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            check("t5_new_addr", q_addr[1], 32'h0);
            check("t5_new_data", q_data[1], 32'h1234_5678);
        end

        // 6) address wrap on the second instance
        sel = 1;
        start_load(16'd2, 1);
        send_word(32'h55AA_55AA, 0);
        send_word(32'h8000_0001, 0);
        drop_valid();
        wait_done();
        check("t6_pulses", q2_addr.size(), 2);
        if (q2_addr.size() == 2) begin
            check("t6_addr0", q2_addr[0], 32'hFFFF_FFFC);
            check("t6_addr1", q2_addr[1], 32'h0);
            check("t6_data0", q2_data[0], 32'h55AA_55AA);
            check("t6_data1", q2_data[1], 32'h8000_0001);
        end
        check("t6_core_rst", core_rst2, 1'b0);
        check("t6_other_untouched", q_addr.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
